// File: rtl/mips_data_mem.sv
// mips_data_mem: word-organised data memory for the core's load/store port.
// Stores land in a small circular write buffer and drain into block RAM on
// cycles without a load; loads always own the RAM port and forward from the
// youngest pending buffered store to the same word.
module mips_data_mem #(
  parameter int WORD_AW    = 10,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   mem_addr,
  input  logic [7:0]                    mem_data_in [0:3],
  input  logic                          mem_write_en,
  input  logic                          mem_read_en,
  input  logic                          halted,
  output logic [7:0]                    mem_data_out [0:3],
  output logic                          mem_stall,
  output logic [$clog2(WBUF_DEPTH):0]   wbuf_count,
  output logic                          drained
);

  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(WBUF_DEPTH);

  // Storage and the RAM read register (no reset, so it maps onto block RAM)
  logic [31:0]        mem_array [0:(1<<WORD_AW)-1];
  logic [31:0]        ram_rd_q;

  // Write buffer entries and control state
  logic [WORD_AW-1:0] wb_idx_q  [WBUF_DEPTH];
  logic [WORD_AW-1:0] wb_idx_d  [WBUF_DEPTH];
  logic [31:0]        wb_data_q [WBUF_DEPTH];
  logic [31:0]        wb_data_d [WBUF_DEPTH];
  logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;
  logic               drained_q, drained_d;

  // Load result path: output is selected from registered pieces
  logic               fwd_hit_q, fwd_hit_d;
  logic [31:0]        fwd_data_q, fwd_data_d;
  logic               out_zero_q, out_zero_d;

  logic [WORD_AW-1:0] word_idx;
  logic [31:0]        store_word;
  logic [31:0]        word_out;
  logic               full, enq, deq, ram_we;
  logic               match_vec [WBUF_DEPTH];
  logic               fwd_hit;
  logic [31:0]        fwd_data;
  logic               unused_addr_bits;

  assign word_idx         = mem_addr[WORD_AW+1:2];
  assign unused_addr_bits = ^{mem_addr[31:WORD_AW+2], mem_addr[1:0]};
  assign store_word       = {mem_data_in[0], mem_data_in[1], mem_data_in[2], mem_data_in[3]};

  // A drain this cycle never frees room for this cycle's store: full uses the registered count
  assign full      = (count_q == DEPTH_C);
  assign enq       = mem_write_en && !full;
  assign deq       = !mem_read_en && (count_q != '0);
  assign ram_we    = deq && !rst;
  assign mem_stall = mem_write_en && full;

  // Per-entry match: entry is live if its age from head is below the count
  generate
    for (genvar gi = 0; gi < WBUF_DEPTH; gi++) begin : g_match
      logic [PW-1:0] age;
      assign age           = PW'(gi) - head_q;
      assign match_vec[gi] = ({1'b0, age} < count_q) && (wb_idx_q[gi] == word_idx);
    end
  endgenerate

  // Youngest-match select: walk oldest to youngest, later hits override
  always_comb begin
    logic [PW-1:0] pos;
    pos      = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      pos = head_q + PW'(k);
      if (match_vec[pos]) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data_q[pos];
      end
    end
  end

  // Next-state for buffer entries: write the tail slot on enqueue
  always_comb begin
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      wb_idx_d[i]  = wb_idx_q[i];
      wb_data_d[i] = wb_data_q[i];
      if (enq && (tail_q == PW'(i))) begin
        wb_idx_d[i]  = word_idx;
        wb_data_d[i] = store_word;
      end
    end
  end

  // Next-state for pointers, count, drained flag and the load result selectors
  always_comb begin
    head_d = deq ? head_q + PW'(1) : head_q;
    tail_d = enq ? tail_q + PW'(1) : tail_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    drained_d  = halted && (count_d == '0);
    fwd_hit_d  = mem_read_en ? fwd_hit  : fwd_hit_q;
    fwd_data_d = mem_read_en ? fwd_data : fwd_data_q;
    out_zero_d = out_zero_q && !mem_read_en;
  end

  // Buffer entry payload registers; reset only needs to clear the count
  always_ff @(posedge clk) begin
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      wb_idx_q[i]  <= wb_idx_d[i];
      wb_data_q[i] <= wb_data_d[i];
    end
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      drained_q  <= 1'b0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
      out_zero_q <= 1'b1;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      drained_q  <= drained_d;
      fwd_hit_q  <= fwd_hit_d;
      fwd_data_q <= fwd_data_d;
      out_zero_q <= out_zero_d;
    end
  end

  // Single storage port: load read, or drain of the head entry when no load
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_array[wb_idx_q[head_q]] <= wb_data_q[head_q];
    end
    if (mem_read_en) begin
      ram_rd_q <= mem_array[word_idx];
    end
  end

  assign word_out   = out_zero_q ? 32'h0 : (fwd_hit_q ? fwd_data_q : ram_rd_q);
  assign wbuf_count = count_q;
  assign drained    = drained_q;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign mem_data_out[gi] = word_out[31-8*gi -: 8];
    end
  endgenerate

endmodule

// File: tb/tb_mips_data_mem.sv
// Scoreboard bench for mips_data_mem: stimulus pushes expected load data,
// a monitor pops and compares on the negedge after each load edge.
module tb_mips_data_mem;

  localparam int WORD_AW    = 10;
  localparam int WBUF_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic [7:0]  din  [0:3];
  logic [7:0]  dout [0:3];
  logic        mem_write_en, mem_read_en, halted;
  logic        mem_stall, drained;
  logic [2:0]  wbuf_count;

  always #5 clk = ~clk;

  mips_data_mem #(.WORD_AW(WORD_AW), .WBUF_DEPTH(WBUF_DEPTH)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_data_in(din),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .halted(halted),
    .mem_data_out(dout), .mem_stall(mem_stall), .wbuf_count(wbuf_count),
    .drained(drained)
  );

  typedef struct {
    logic [31:0] data;
    bit          dc;
    int          id;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   load_id   = 0;

  function automatic logic [31:0] dout_word();
    return {dout[0], dout[1], dout[2], dout[3]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic we, input logic re, input logic [31:0] addr, input logic [31:0] data);
    mem_write_en = we;
    mem_read_en  = re;
    mem_addr     = addr;
    din[0] = data[31:24];
    din[1] = data[23:16];
    din[2] = data[15:8];
    din[3] = data[7:0];
  endtask

  task automatic push_load(input logic [31:0] d, input bit dc);
    exp_t e;
    e.data = d;
    e.dc   = dc;
    e.id   = load_id;
    load_id++;
    sb_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a load accepted at a posedge is checked at the following negedge
  initial begin
    bit   pend;
    exp_t e;
    forever begin
      @(posedge clk);
      pend = mem_read_en && !rst;
      @(negedge clk);
      if (pend) begin
        if (sb_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_load: got %h expected no load", dout_word());
        end else begin
          e = sb_q.pop_front();
          if (!e.dc) begin
            check($sformatf("load%0d", e.id), dout_word(), e.data);
            $display("load %0d data=%h exp=%h", e.id, dout_word(), e.data);
          end else begin
            $display("load %0d data=%h (unchecked)", e.id, dout_word());
          end
        end
      end
    end
  end

  initial begin
    rst    = 1'b1;
    halted = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();
    rst = 1'b0;
    check("reset_dout", dout_word(), 32'h0);
    check("reset_count", 32'(wbuf_count), 32'd0);
    check("reset_drained", 32'(drained), 32'd0);

    // Load of an unwritten word: only the pre-edge zero is defined
    drive(1'b0, 1'b1, 32'h10, 32'h0);
    push_load(32'h0, 1'b1);
    check("pre_load_zero", dout_word(), 32'h0);
    step();

    // Store then forwarded load
    drive(1'b1, 1'b0, 32'h20, 32'hDEADBEEF);
    step();
    check("t2_count_store", 32'(wbuf_count), 32'd1);
    drive(1'b0, 1'b1, 32'h20, 32'h0);
    push_load(32'hDEADBEEF, 1'b0);
    step();
    check("t2_count_load", 32'(wbuf_count), 32'd1);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    check("t2_count_drain", 32'(wbuf_count), 32'd0);
    check("t2_dout_hold", dout_word(), 32'hDEADBEEF);

    // Same-cycle store and load return the old word
    drive(1'b1, 1'b0, 32'h40, 32'hAAAAAAAA);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    check("t3_count_drain", 32'(wbuf_count), 32'd0);
    drive(1'b1, 1'b1, 32'h40, 32'h11223344);
    push_load(32'hAAAAAAAA, 1'b0);
    step();
    check("t3_count", 32'(wbuf_count), 32'd1);
    drive(1'b0, 1'b1, 32'h40, 32'h0);
    push_load(32'h11223344, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    step();

    // Fill the buffer while loads starve draining, then stall and retry
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'h20, 32'h01010101 * (i + 1));
      #1;
      check($sformatf("t4_nostall%0d", i), 32'(mem_stall), 32'd0);
      push_load((i == 0) ? 32'hDEADBEEF : 32'h01010101 * i, 1'b0);
      step();
    end
    check("t4_count_full", 32'(wbuf_count), 32'd4);
    drive(1'b1, 1'b1, 32'h20, 32'h05050505);
    #1;
    check("t4_stall_full", 32'(mem_stall), 32'd1);
    push_load(32'h04040404, 1'b0);
    step();
    check("t4_count_held", 32'(wbuf_count), 32'd4);
    drive(1'b1, 1'b0, 32'h20, 32'h05050505);
    #1;
    check("t4_stall_drain_cycle", 32'(mem_stall), 32'd1);
    step();
    check("t4_count_after_drain", 32'(wbuf_count), 32'd3);
    check("t4_retry_nostall", 32'(mem_stall), 32'd0);
    step();
    check("t4_count_retry", 32'(wbuf_count), 32'd3);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) step();
    check("t4_count_empty", 32'(wbuf_count), 32'd0);
    drive(1'b0, 1'b1, 32'h20, 32'h0);
    push_load(32'h05050505, 1'b0);
    step();

    // Youngest-match forwarding with two stores to one word
    drive(1'b1, 1'b0, 32'h80, 32'hCAFEF00D);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    drive(1'b1, 1'b1, 32'h80, 32'h1);
    push_load(32'hCAFEF00D, 1'b0);
    step();
    drive(1'b1, 1'b1, 32'h80, 32'h2);
    push_load(32'h1, 1'b0);
    step();
    check("t5_count", 32'(wbuf_count), 32'd2);
    drive(1'b0, 1'b1, 32'h80, 32'h0);
    push_load(32'h2, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) step();
    check("t5_count_empty", 32'(wbuf_count), 32'd0);
    drive(1'b0, 1'b1, 32'h80, 32'h0);
    push_load(32'h2, 1'b0);
    step();

    // Halt with three entries pending
    drive(1'b1, 1'b1, 32'h80, 32'h3);
    push_load(32'h2, 1'b0);
    step();
    drive(1'b1, 1'b1, 32'h80, 32'h4);
    push_load(32'h3, 1'b0);
    step();
    drive(1'b1, 1'b1, 32'h80, 32'h5);
    push_load(32'h4, 1'b0);
    step();
    check("t6_count", 32'(wbuf_count), 32'd3);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    halted = 1'b1;
    step();
    check("t6_drained_e1", 32'(drained), 32'd0);
    step();
    check("t6_drained_e2", 32'(drained), 32'd0);
    step();
    check("t6_drained_e3", 32'(drained), 32'd1);
    check("t6_count_empty", 32'(wbuf_count), 32'd0);
    step();
    check("t6_drained_stay", 32'(drained), 32'd1);
    halted = 1'b0;
    step();
    check("t6_drained_fall", 32'(drained), 32'd0);

    // Reset with two entries pending discards them
    drive(1'b1, 1'b0, 32'h300, 32'h99887766);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    drive(1'b1, 1'b1, 32'h300, 32'h13572468);
    push_load(32'h99887766, 1'b0);
    step();
    drive(1'b1, 1'b1, 32'h300, 32'h24681357);
    push_load(32'h13572468, 1'b0);
    step();
    check("t7_count", 32'(wbuf_count), 32'd2);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t7_rst_count", 32'(wbuf_count), 32'd0);
    check("t7_rst_dout", dout_word(), 32'h0);
    check("t7_rst_drained", 32'(drained), 32'd0);
    drive(1'b0, 1'b1, 32'h300, 32'h0);
    push_load(32'h99887766, 1'b0);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);

    // Bounded wait for the scoreboard to empty
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      total_cnt++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
